fwd_hazard_unit: RTL and testbench

Tracks destination registers of the instructions in EX, MEM and WB, and generates the 2-bit select codes for the two operand-forwarding 3:1 muxes ahead of the ALU. Also detects load-use hazards, stalls PC and IF/ID, and inserts a bubble into ID/EX. Sits beside the ID/EX pipeline register and drives the ALU operand muxes directly. Keeps its own shadow copy of the pipeline's rd/control bits, so it needs no taps from the datapath registers.

---
 rtl/fwd_hazard_unit.sv | 124 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use hazard unit.
// Tracks a private shadow of the EX/MEM/WB destination and control bits.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  ex_bubble,
    output logic [CNT_W-1:0]      stall_count
);

    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_use1_q, ex_use1_d;
    logic                  ex_use2_q, ex_use2_d;
    logic                  ex_rw_q, ex_rw_d;
    logic                  ex_mr_q, ex_mr_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, wb_rd_q;
    logic                  mem_rw_q, wb_rw_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic mem_eff, wb_eff, ex_load_eff, rs1_hit, rs2_hit;

    assign mem_eff     = mem_rw_q && (mem_rd_q != '0);
    assign wb_eff      = wb_rw_q && (wb_rd_q != '0);
    assign ex_load_eff = ex_mr_q && ex_rw_q && (ex_rd_q != '0);
    assign rs1_hit     = id_use_rs1 && (id_rs1 == ex_rd_q);
    assign rs2_hit     = id_use_rs2 && (id_rs2 == ex_rd_q);

    // flush squashes the ID instruction, so a hazard against it is moot
    assign stall          = id_valid && ex_load_eff && (rs1_hit || rs2_hit) && !flush;
    assign ex_bubble      = stall || flush;
    assign pc_write_en    = !stall;
    assign if_id_write_en = !stall;
    assign stall_count    = cnt_q;

    always_comb begin
        fwd_a_sel = 2'b00;
        if (ex_use1_q && mem_eff && (mem_rd_q == ex_rs1_q))
            fwd_a_sel = 2'b10;
        else if (ex_use1_q && wb_eff && (wb_rd_q == ex_rs1_q))
            fwd_a_sel = 2'b01;
    end

    always_comb begin
        fwd_b_sel = 2'b00;
        if (ex_use2_q && mem_eff && (mem_rd_q == ex_rs2_q))
            fwd_b_sel = 2'b10;
        else if (ex_use2_q && wb_eff && (wb_rd_q == ex_rs2_q))
            fwd_b_sel = 2'b01;
    end

    always_comb begin
        ex_rs1_d  = '0;
        ex_rs2_d  = '0;
        ex_rd_d   = '0;
        ex_use1_d = 1'b0;
        ex_use2_d = 1'b0;
        ex_rw_d   = 1'b0;
        ex_mr_d   = 1'b0;
        if (id_valid && !ex_bubble) begin
            ex_rs1_d  = id_rs1;
            ex_rs2_d  = id_rs2;
            ex_rd_d   = id_rd;
            ex_use1_d = id_use_rs1;
            ex_use2_d = id_use_rs2;
            ex_rw_d   = id_reg_write;
            ex_mr_d   = id_mem_read;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_rd_q   <= '0;
            ex_use1_q <= 1'b0;
            ex_use2_q <= 1'b0;
            ex_rw_q   <= 1'b0;
            ex_mr_q   <= 1'b0;
            mem_rd_q  <= '0;
            mem_rw_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_rw_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ex_rs1_q  <= ex_rs1_d;
            ex_rs2_q  <= ex_rs2_d;
            ex_rd_q   <= ex_rd_d;
            ex_use1_q <= ex_use1_d;
            ex_use2_q <= ex_use2_d;
            ex_rw_q   <= ex_rw_d;
            ex_mr_q   <= ex_mr_d;
            mem_rd_q  <= ex_rd_q;
            mem_rw_q  <= ex_rw_q;
            wb_rd_q   <= mem_rd_q;
            wb_rw_q   <= mem_rw_q;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plus random bench for fwd_hazard_unit against an instruction-level pipeline model.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;

    logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_a2, fwd_b2;
    logic        stall, pc_write_en, if_id_write_en, ex_bubble;
    logic        stall2, pcwe2, ifidwe2, bubble2;
    logic [31:0] stall_count;
    logic [1:0]  stall_count2;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .ex_bubble(ex_bubble), .stall_count(stall_count)
    );

    fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(fwd_a2), .fwd_b_sel(fwd_b2), .stall(stall2),
        .pc_write_en(pcwe2), .if_id_write_en(ifidwe2),
        .ex_bubble(bubble2), .stall_count(stall_count2)
    );

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        bit         u1, u2, rw, mr;
    } ins_t;

    ins_t        m_ex, m_mem, m_wb, m_id;
    bit          m_valid, m_flush;
    longint      m_cnt, m_cnt2;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cnt_before;

    function automatic ins_t nop_ins();
        ins_t i;
        i.rs1 = '0; i.rs2 = '0; i.rd = '0;
        i.u1 = 0; i.u2 = 0; i.rw = 0; i.mr = 0;
        return i;
    endfunction

    function automatic bit writes(ins_t i);
        return i.rw && (i.rd != 0);
    endfunction

    // Newest producer wins; the register file covers anything older than WB
    function automatic logic [1:0] exp_sel(logic [4:0] src, bit used);
        if (!used) return 2'b00;
        if (writes(m_mem) && m_mem.rd == src) return 2'b10;
        if (writes(m_wb) && m_wb.rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_stall();
        bit dep;
        dep = (m_id.u1 && m_id.rs1 == m_ex.rd) || (m_id.u2 && m_id.rs2 == m_ex.rd);
        return m_valid && m_ex.mr && writes(m_ex) && dep && !m_flush;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ex = nop_ins(); m_mem = nop_ins(); m_wb = nop_ins();
        m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic drive(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input logic [4:0] rd,
                         input bit rw, input bit mr, input bit fl);
        m_valid = v; m_flush = fl;
        m_id.rs1 = rs1; m_id.rs2 = rs2; m_id.rd = rd;
        m_id.u1 = u1; m_id.u2 = u2; m_id.rw = rw; m_id.mr = mr;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
    endtask

    // Check every output against the model, then advance one clock
    task automatic tick();
        bit s, b;
        s = exp_stall();
        b = s || m_flush;
        chk("stall", {31'b0, stall}, {31'b0, s});
        chk("pc_we", {31'b0, pc_write_en}, {31'b0, !s});
        chk("ifid_we", {31'b0, if_id_write_en}, {31'b0, !s});
        chk("bubble", {31'b0, ex_bubble}, {31'b0, b});
        chk("fwd_a", {30'b0, fwd_a_sel}, {30'b0, exp_sel(m_ex.rs1, m_ex.u1)});
        chk("fwd_b", {30'b0, fwd_b_sel}, {30'b0, exp_sel(m_ex.rs2, m_ex.u2)});
        chk("cnt", stall_count, m_cnt[31:0]);
        chk("cnt_sat", {30'b0, stall_count2}, m_cnt2[31:0]);
        @(posedge clk);
        if (s) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        m_wb = m_mem;
        m_mem = m_ex;
        m_ex = (m_valid && !b) ? m_id : nop_ins();
        #1;
    endtask

    task automatic issue(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input logic [4:0] rd,
                         input bit rw, input bit mr, input bit fl);
        drive(v, rs1, rs2, u1, u2, rd, rw, mr, fl);
        #1;
        tick();
    endtask

    task automatic bubble_id();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fwd_a"}, {30'b0, fwd_a_sel}, 32'd0);
        chk({tag, "_fwd_b"}, {30'b0, fwd_b_sel}, 32'd0);
        chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, "_pc_we"}, {31'b0, pc_write_en}, 32'd1);
        chk({tag, "_ifid_we"}, {31'b0, if_id_write_en}, 32'd1);
        chk({tag, "_bubble"}, {31'b0, ex_bubble}, 32'd0);
        chk({tag, "_cnt"}, stall_count, 32'd0);
        chk({tag, "_cnt_sat"}, {30'b0, stall_count2}, 32'd0);
    endtask

    initial begin
        model_reset();
        m_id = nop_ins();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_reset_outputs("reset");
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // add x5 ; sub x6,x5,x7
        issue(1, 1, 2, 1, 1, 5, 1, 0, 0);
        issue(1, 5, 7, 1, 1, 6, 1, 0, 0);
        chk("chain_fwd_a", {30'b0, fwd_a_sel}, 32'h2);
        chk("chain_fwd_b", {30'b0, fwd_b_sel}, 32'h0);
        bubble_id();

        // add x5 ; nop ; or x8,x5,x5
        issue(1, 1, 2, 1, 1, 5, 1, 0, 0);
        bubble_id();
        issue(1, 5, 5, 1, 1, 8, 1, 0, 0);
        chk("dist2_fwd_a", {30'b0, fwd_a_sel}, 32'h1);
        chk("dist2_fwd_b", {30'b0, fwd_b_sel}, 32'h1);

        // add x5 ; add x5 ; or x8,x5,x5  -> MEM beats WB
        issue(1, 1, 2, 1, 1, 5, 1, 0, 0);
        issue(1, 3, 4, 1, 1, 5, 1, 0, 0);
        issue(1, 5, 5, 1, 1, 8, 1, 0, 0);
        chk("prio_fwd_a", {30'b0, fwd_a_sel}, 32'h2);
        chk("prio_fwd_b", {30'b0, fwd_b_sel}, 32'h2);
        bubble_id(); bubble_id(); bubble_id();

        // lw x9 ; add x10,x9,x1
        cnt_before = stall_count;
        issue(1, 2, 0, 1, 0, 9, 1, 1, 0);
        drive(1, 9, 1, 1, 1, 10, 1, 0, 0);
        #1;
        chk("lu_stall", {31'b0, stall}, 32'd1);
        chk("lu_pc_we", {31'b0, pc_write_en}, 32'd0);
        chk("lu_bubble", {31'b0, ex_bubble}, 32'd1);
        tick();
        chk("lu_cnt_inc", stall_count, cnt_before + 32'd1);
        drive(1, 9, 1, 1, 1, 10, 1, 0, 0);
        #1;
        chk("lu_release", {31'b0, stall}, 32'd0);
        tick();
        chk("lu_fwd_a", {30'b0, fwd_a_sel}, 32'h1);
        bubble_id(); bubble_id();

        // lw x0 ; add x1,x0,x0
        issue(1, 2, 0, 1, 0, 0, 1, 1, 0);
        drive(1, 0, 0, 1, 1, 1, 1, 0, 0);
        #1;
        chk("x0_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("x0_fwd_a", {30'b0, fwd_a_sel}, 32'h0);
        chk("x0_fwd_b", {30'b0, fwd_b_sel}, 32'h0);
        bubble_id(); bubble_id();

        // lw x9 ; consumer with rs2=x9 but use_rs2=0
        issue(1, 2, 0, 1, 0, 9, 1, 1, 0);
        drive(1, 3, 9, 1, 0, 11, 1, 0, 0);
        #1;
        chk("unused_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("unused_fwd_b", {30'b0, fwd_b_sel}, 32'h0);
        bubble_id(); bubble_id();

        // lw x9 ; add x10,x9,x1 with flush ; or x11,x10,x10
        issue(1, 2, 0, 1, 0, 9, 1, 1, 0);
        cnt_before = stall_count;
        drive(1, 9, 1, 1, 1, 10, 1, 0, 1);
        #1;
        chk("flush_stall", {31'b0, stall}, 32'd0);
        chk("flush_bubble", {31'b0, ex_bubble}, 32'd1);
        tick();
        issue(1, 10, 10, 1, 1, 11, 1, 0, 0);
        chk("flush_squashed", {30'b0, fwd_a_sel}, 32'h0);
        chk("flush_no_cnt", stall_count, cnt_before);
        bubble_id(); bubble_id();

        // four more load-use stalls: narrow counter pins at 3
        for (int k = 0; k < 4; k++) begin
            issue(1, 2, 0, 1, 0, 9, 1, 1, 0);
            issue(1, 9, 1, 1, 1, 10, 1, 0, 0);
            issue(1, 9, 1, 1, 1, 10, 1, 0, 0);
        end
        chk("sat_hold", {30'b0, stall_count2}, 32'd3);
        bubble_id(); bubble_id();

        // reset asserted in the middle of a stall
        issue(1, 2, 0, 1, 0, 9, 1, 1, 0);
        drive(1, 9, 1, 1, 1, 10, 1, 0, 0);
        #1;
        chk("pre_rst_stall", {31'b0, stall}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 400; n++) begin
            issue($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
